// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule widths, PC1/PC2 index tables, rotate tables and FSM state type.
package des_pkg;
    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    typedef enum logic {IDLE, EMIT} state_t;

    // Entries are FIPS 46-3 bit numbers: bit 1 is the MSB of the source vector
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_ENC [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt walks the encrypt schedule backwards, starting from C16D16 == C0D0
    localparam logic [1:0] SHIFT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] rot28(input logic [CD_W-1:0] x, input logic [1:0] n,
                                              input logic right);
        return right ? (n == 2'd2 ? {x[1:0], x[27:2]} : n == 2'd1 ? {x[0], x[27:1]} : x)
                     : (n == 2'd2 ? {x[25:0], x[27:26]} : n == 2'd1 ? {x[26:0], x[27]} : x);
    endfunction
endpackage

// File: rtl/des_pc1.sv
// des_pc1: Permuted Choice 1, 64-bit key to 56-bit C0D0; byte parity bits are dropped.
module des_pc1
    import des_pkg::*;
(
    input  logic [KEY_W-1:0]  key,
    output logic [2*CD_W-1:0] cd
);
    logic unused_parity;

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign cd[55-g] = key[64-PC1_TBL[g]];
    end

    assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
endmodule

// File: rtl/des_pc2.sv
// des_pc2: Permuted Choice 2, 56-bit CD to 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0] cd,
    output logic [SUBKEY_W-1:0] subkey
);
    logic unused_cd;

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign subkey[47-g] = cd[56-PC2_TBL[g]];
    end

    assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};
endmodule

// File: rtl/des_key_schedule_ctrl.sv
// des_key_schedule_ctrl: DES subkey sequencer (K1..K16 or K16..K1); DES_KEY_PARITY_CHECK_EN adds odd-parity key rejection.
module des_key_schedule_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int SUBKEY_W   = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_W-1:0]    key,
    input  logic                decrypt,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          round,
    output logic                last,
    output logic                busy
`ifdef DES_KEY_PARITY_CHECK_EN
    , output logic              parity_err
`endif
);
    state_t state_q, state_d;
    logic [2*CD_W-1:0] cd_q, cd_d, cd_load, cd_src, cd_rot;
    logic [SUBKEY_W-1:0] subkey_q, subkey_d, subkey_next;
    logic [3:0] round_q, round_d, idx;
    logic [1:0] amt;
    logic dec_q, dec_d, dir, accept, handshake, key_ok;

    des_pc1 u_pc1 (.key(key), .cd(cd_load));
    des_pc2 u_pc2 (.cd(cd_rot), .subkey(subkey_next));

`ifdef DES_KEY_PARITY_CHECK_EN
    logic [7:0] byte_odd;
    logic parity_err_q, parity_err_d;
    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^key[8*b +: 8];
    end
    assign key_ok       = &byte_odd;
    assign parity_err_d = accept && !key_ok;
    assign parity_err   = parity_err_q;
    always_ff @(posedge clk)
        parity_err_q <= rst ? 1'b0 : parity_err_d;
`else
    assign key_ok = 1'b1;
`endif

    assign key_ready    = state_q == IDLE;
    assign subkey_valid = state_q == EMIT;
    assign busy         = state_q == EMIT;
    assign subkey       = subkey_q;
    assign round        = round_q;
    assign last         = round_q == 4'd15;

    // One shared rotate+PC2 path serves both the load step and every later round
    assign accept    = key_valid && state_q == IDLE;
    assign handshake = state_q == EMIT && subkey_ready;
    assign idx       = accept ? 4'd0 : round_q + 4'd1;
    assign dir       = accept ? decrypt : dec_q;
    assign cd_src    = accept ? cd_load : cd_q;
    assign amt       = dir ? SHIFT_DEC[idx] : SHIFT_ENC[idx];
    assign cd_rot    = {rot28(cd_src[2*CD_W-1:CD_W], amt, dir), rot28(cd_src[CD_W-1:0], amt, dir)};

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        subkey_d = subkey_q;
        round_d  = round_q;
        dec_d    = dec_q;
        if (accept && key_ok) begin
            state_d  = EMIT;
            cd_d     = cd_rot;
            subkey_d = subkey_next;
            round_d  = 4'd0;
            dec_d    = decrypt;
        end
        if (handshake) begin
            state_d  = last ? IDLE : EMIT;
            round_d  = last ? 4'd0 : idx;
            cd_d     = last ? cd_q : cd_rot;
            subkey_d = last ? subkey_q : subkey_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cd_q     <= '0;
            subkey_q <= '0;
            round_q  <= 4'd0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
            dec_q    <= dec_d;
        end
    end

    always_ff @(posedge clk)
        if (!rst && subkey_valid && last)
            assert (round == 4'(NUM_ROUNDS - 1));
endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// tb_des_key_schedule_ctrl: directed checks of the DES key schedule sequencer against the FIPS example key.
module tb_des_key_schedule_ctrl;
    logic clk = 1'b0;
    logic rst, key_valid, key_ready, decrypt, subkey_valid, subkey_ready, last, busy;
    logic [63:0] key;
    logic [47:0] subkey;
    logic [3:0]  round;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic parity_err;
`endif
    int errors = 0;
    int checks = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
`ifdef DES_KEY_PARITY_CHECK_EN
    localparam logic [63:0] KEY_B = 64'h133457799BBCDFF1;
`else
    // Differs from KEY_A only in parity bits, so it yields the same subkeys
    localparam logic [63:0] KEY_B = 64'h123456789ABCDEF0;
`endif

    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .decrypt(decrypt), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .subkey(subkey), .round(round), .last(last), .busy(busy)
`ifdef DES_KEY_PARITY_CHECK_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; key_valid = 1'b0; key = '0; decrypt = 1'b0; subkey_ready = 1'b0;
        tick; tick;
        checks++;
        if ({key_ready, subkey_valid, busy, last} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got rdy/vld/busy/last=%b want 1000", {key_ready, subkey_valid, busy, last});
        end
        checks++;
        if ({round, subkey} !== 52'd0) begin
            errors++;
            $display("FAIL reset_data got round=%0d subkey=%h want 0/0", round, subkey);
        end
        rst = 1'b0;
        tick;
        checks++;
        if ({key_ready, subkey_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle got rdy/vld=%b want 10", {key_ready, subkey_valid});
        end
    endtask

    task automatic run_schedule(input string name, input logic [63:0] k, input logic dec);
        key = k; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b1;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_key_ready got %b want 1", name, key_ready);
        end
        tick;
        key_valid = 1'b0;
        decrypt = ~dec;
        for (int r = 0; r < 16; r++) begin
            checks++;
            if ({subkey_valid, busy, key_ready, round, last, subkey} !==
                {1'b1, 1'b1, 1'b0, 4'(r), r == 15, dec ? ks[15-r] : ks[r]}) begin
                errors++;
                $display("FAIL %s_r%0d got vld=%b busy=%b rdy=%b round=%0d last=%b subkey=%h want subkey=%h",
                         name, r, subkey_valid, busy, key_ready, round, last, subkey, dec ? ks[15-r] : ks[r]);
            end
            tick;
        end
        checks++;
        if ({subkey_valid, busy, key_ready, last} !== 4'b0010) begin
            errors++;
            $display("FAIL %s_done got vld/busy/rdy/last=%b want 0010", name, {subkey_valid, busy, key_ready, last});
        end
    endtask

    task automatic test_encrypt;
        run_schedule("enc", KEY_A, 1'b0);
    endtask

    task automatic test_decrypt;
        run_schedule("dec", KEY_A, 1'b1);
    endtask

    task automatic test_backpressure;
        int stalls;
        key = KEY_A; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b0;
        tick;
        key_valid = 1'b0;
        for (int r = 0; r < 16; r++) begin
            stalls = (r == 0 || r == 8 || r == 15) ? 3 : int'($urandom_range(0, 1));
            for (int s = 0; s <= stalls; s++) begin
                checks++;
                if ({subkey_valid, round, last, subkey} !== {1'b1, 4'(r), r == 15, ks[r]}) begin
                    errors++;
                    $display("FAIL bp_r%0d_s%0d got vld=%b round=%0d last=%b subkey=%h want %h",
                             r, s, subkey_valid, round, last, subkey, ks[r]);
                end
                subkey_ready = (s == stalls);
                tick;
            end
        end
        subkey_ready = 1'b1;
        checks++;
        if ({subkey_valid, key_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_done got vld/rdy=%b want 01", {subkey_valid, key_ready});
        end
    endtask

    task automatic test_busy_lockout;
        key = KEY_A; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
        tick;
        key = KEY_B;
        for (int r = 0; r < 16; r++) begin
            checks++;
            if ({key_ready, subkey_valid, round, subkey} !== {1'b0, 1'b1, 4'(r), ks[r]}) begin
                errors++;
                $display("FAIL lock_r%0d got rdy=%b vld=%b round=%0d subkey=%h want %h",
                         r, key_ready, subkey_valid, round, subkey, ks[r]);
            end
            tick;
        end
        checks++;
        if ({key_ready, subkey_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL lock_idle got rdy/vld/busy=%b want 100", {key_ready, subkey_valid, busy});
        end
        tick;
        key_valid = 1'b0;
        checks++;
        if ({subkey_valid, round, subkey} !== {1'b1, 4'd0, ks[0]}) begin
            errors++;
            $display("FAIL lock_second got vld=%b round=%0d subkey=%h want %h", subkey_valid, round, subkey, ks[0]);
        end
        for (int r = 0; r < 16; r++) tick;
        checks++;
        if ({subkey_valid, key_ready} !== 2'b01) begin
            errors++;
            $display("FAIL lock_done got vld/rdy=%b want 01", {subkey_valid, key_ready});
        end
    endtask

    task automatic test_reset_mid;
        key = KEY_A; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
        tick;
        key_valid = 1'b0;
        for (int r = 0; r < 7; r++) tick;
        checks++;
        if ({round, subkey} !== {4'd7, ks[7]}) begin
            errors++;
            $display("FAIL rmid_r7 got round=%0d subkey=%h want 7/%h", round, subkey, ks[7]);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({subkey_valid, key_ready, busy, round} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rmid_abort got vld=%b rdy=%b busy=%b round=%0d want 0 1 0 0",
                     subkey_valid, key_ready, busy, round);
        end
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        checks++;
        if ({subkey_valid, round, subkey} !== {1'b1, 4'd0, ks[0]}) begin
            errors++;
            $display("FAIL rmid_fresh got vld=%b round=%0d subkey=%h want %h", subkey_valid, round, subkey, ks[0]);
        end
        for (int r = 0; r < 16; r++) tick;
        checks++;
        if ({subkey_valid, key_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rmid_done got vld/rdy=%b want 01", {subkey_valid, key_ready});
        end
    endtask

`ifdef DES_KEY_PARITY_CHECK_EN
    task automatic test_parity;
        key = 64'h133457799BBCDFF0; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
        tick;
        key_valid = 1'b0;
        checks++;
        if ({parity_err, subkey_valid, key_ready} !== 3'b101) begin
            errors++;
            $display("FAIL par_bad got perr/vld/rdy=%b want 101", {parity_err, subkey_valid, key_ready});
        end
        tick;
        checks++;
        if ({parity_err, subkey_valid} !== 2'b00) begin
            errors++;
            $display("FAIL par_pulse got perr/vld=%b want 00", {parity_err, subkey_valid});
        end
        key = KEY_A; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        checks++;
        if ({parity_err, subkey_valid, subkey} !== {1'b0, 1'b1, ks[0]}) begin
            errors++;
            $display("FAIL par_good got perr=%b vld=%b subkey=%h want 0 1 %h", parity_err, subkey_valid, subkey, ks[0]);
        end
        for (int r = 0; r < 16; r++) tick;
    endtask
`endif

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_busy_lockout;
        test_reset_mid;
`ifdef DES_KEY_PARITY_CHECK_EN
        test_parity;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not reach the summary");
        $fatal(1);
    end
endmodule
